// File: rtl/grf_wb_if.sv
// GRF write-side bundle: pipeline writeback, late-result handshake, hazard query, GRF write port.
// Pure wiring; no latency of its own.
// Backpressure exists only on the late-result channel (m_valid/m_ready).
interface grf_wb_if #(
  parameter int AW = 2
);
  logic          p_valid;
  logic [4:0]    p_addr;
  logic [31:0]   p_data;
  logic [31:0]   p_pc;
  logic          m_valid;
  logic          m_ready;
  logic [4:0]    m_addr;
  logic [31:0]   m_data;
  logic [31:0]   m_pc;
  logic [4:0]    q_addr0;
  logic [4:0]    q_addr1;
  logic          q_busy0;
  logic          q_busy1;
  logic          RegWrite;
  logic [4:0]    Waddr;
  logic [31:0]   WData;
  logic [31:0]   PC;
  logic [AW:0]   count;

  // Arbiter side
  modport master (
    input  p_valid, p_addr, p_data, p_pc,
    input  m_valid, m_addr, m_data, m_pc,
    input  q_addr0, q_addr1,
    output m_ready, q_busy0, q_busy1,
    output RegWrite, Waddr, WData, PC, count
  );

  // Producer / consumer side
  modport slave (
    output p_valid, p_addr, p_data, p_pc,
    output m_valid, m_addr, m_data, m_pc,
    output q_addr0, q_addr1,
    input  m_ready, q_busy0, q_busy1,
    input  RegWrite, Waddr, WData, PC, count
  );
endinterface

// File: rtl/grf_wb_arbiter.sv
// Owns the GRF write port: pipeline writeback wins, late results drain from a DEPTH-entry FIFO.
// One cycle from selection to registered GRF write; late results take at least two cycles.
// m_ready drops only when the FIFO is full; the pipeline channel is never stalled.
module grf_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic     clk,
  input  logic     reset,
  grf_wb_if.master bus
);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  entry_t          mem [DEPTH];
  logic [DEPTH-1:0] kill;
  logic [DEPTH-1:0] live;
  logic [AW-1:0]   offs [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     cnt;
  logic            p_req, pop, push;
  entry_t          head;

  logic            reg_write;
  logic [4:0]      waddr;
  logic [31:0]     wdata;
  logic [31:0]     wpc;
  logic            busy0, busy1;

  // A write to r0 is a no-op, so it is never treated as a request
  assign p_req = bus.p_valid && (bus.p_addr != 5'd0);
  assign pop   = !p_req && (cnt != '0);
  assign push  = bus.m_valid && bus.m_ready && (bus.m_addr != 5'd0);
  assign head  = mem[rd_ptr];

  // Ready depends on registered occupancy only, so a full FIFO never pops through
  assign bus.m_ready = reset && (cnt != FULL);

  // Mark slots holding a live entry: inside the occupied window and not superseded
  always_comb begin
    live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs[i] = AW'(i) - rd_ptr;
      live[i] = ({1'b0, offs[i]} < cnt) && !kill[i];
    end
  end

  // Hazard query covers queued entries only; the output register is bypassed in the GRF
  always_comb begin
    busy0 = 1'b0;
    busy1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && (mem[i].addr == bus.q_addr0)) busy0 = 1'b1;
      if (live[i] && (mem[i].addr == bus.q_addr1)) busy1 = 1'b1;
    end
    busy0 = busy0 && (bus.q_addr0 != 5'd0);
    busy1 = busy1 && (bus.q_addr1 != 5'd0);
  end

  assign bus.q_busy0  = busy0;
  assign bus.q_busy1  = busy1;
  assign bus.RegWrite = reg_write;
  assign bus.Waddr    = waddr;
  assign bus.WData    = wdata;
  assign bus.PC       = wpc;
  assign bus.count    = cnt;

  // Payload storage needs no reset; occupancy and kill bits guard stale contents
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: bus.m_addr, data: bus.m_data, pc: bus.m_pc};
  end

  // Output selection, FIFO pointers and kill tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      kill      <= '0;
      reg_write <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      wpc       <= '0;
    end else begin
      if (p_req) begin
        reg_write <= 1'b1;
        waddr     <= bus.p_addr;
        wdata     <= bus.p_data;
        wpc       <= bus.p_pc;
      end else if (pop) begin
        reg_write <= !kill[rd_ptr];
        if (!kill[rd_ptr]) begin
          waddr <= head.addr;
          wdata <= head.data;
          wpc   <= head.pc;
        end
      end else begin
        reg_write <= 1'b0;
      end

      // Newer pipeline value supersedes older queued writes to the same register;
      // stale slots may get marked too, but a push always clears its slot
      for (int i = 0; i < DEPTH; i++) begin
        if (p_req && (mem[i].addr == bus.p_addr)) kill[i] <= 1'b1;
      end

      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) begin
        wr_ptr       <= wr_ptr + 1'b1;
        kill[wr_ptr] <= 1'b0;
      end

      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Self-checking bench for grf_wb_arbiter: expected GRF writes queued as stimulus is driven,
// checked in order whenever RegWrite is seen; direct checks on timing, flow control and hazards.
// Inputs change 1ns after posedge; outputs sampled at #1 after posedge or at negedge.
module tb_grf_wb_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
  } wr_t;

  wr_t exp_q[$];

  always #5 clk = ~clk;

  grf_wb_if #(.AW(2)) bus ();

  grf_wb_arbiter #(.DEPTH(4), .AW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  task automatic chk(input string tag, input logic [68:0] got, input logic [68:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
    exp_q.push_back('{a: a, d: d, pc: pc});
  endtask

  // Scoreboard: every GRF write must be the next expected one
  always @(negedge clk) begin
    if (reset && bus.RegWrite) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {1'b1, bus.Waddr, bus.WData, bus.PC}, '0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("sb_write", {1'b0, bus.Waddr, bus.WData, bus.PC}, {1'b0, e.a, e.d, e.pc});
      end
    end
  end

  initial begin
    reset       = 1'b0;
    bus.p_valid = 1'b0; bus.p_addr = '0; bus.p_data = '0; bus.p_pc = '0;
    bus.m_valid = 1'b1; bus.m_addr = 5'd3; bus.m_data = 32'hDEAD; bus.m_pc = '0;
    bus.q_addr0 = '0;   bus.q_addr1 = '0;

    // Reset held with a pending late request
    repeat (3) step();
    chk("rst_regwrite", bus.RegWrite, 0);
    chk("rst_mready",   bus.m_ready, 0);
    chk("rst_count",    bus.count, 0);
    chk("rst_outs",     {bus.Waddr, bus.WData, bus.PC}, 0);
    bus.m_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rel_mready", bus.m_ready, 1);

    // Pipeline write, one-cycle latency
    bus.p_valid = 1'b1; bus.p_addr = 5'd5; bus.p_data = 32'h1234; bus.p_pc = 32'h3000;
    exp_wr(5'd5, 32'h1234, 32'h3000);
    step();
    chk("p_write", {bus.RegWrite, bus.Waddr, bus.WData, bus.PC}, {1'b1, 5'd5, 32'h1234, 32'h3000});
    bus.p_addr = 5'd0; bus.p_data = 32'h5555;
    step();
    chk("p_r0_regwrite", bus.RegWrite, 0);
    chk("p_r0_hold", {bus.Waddr, bus.WData}, {5'd5, 32'h1234});
    bus.p_valid = 1'b0;

    // Late result through the FIFO
    bus.m_valid = 1'b1; bus.m_addr = 5'd8; bus.m_data = 32'hABCD; bus.m_pc = 32'h4000;
    exp_wr(5'd8, 32'hABCD, 32'h4000);
    step();
    bus.m_valid = 1'b0; bus.q_addr0 = 5'd8; bus.q_addr1 = 5'd9;
    #1;
    chk("m_count1", bus.count, 1);
    chk("m_busy", {bus.q_busy0, bus.q_busy1, bus.RegWrite}, 3'b100);
    step();
    chk("m_write", {bus.RegWrite, bus.Waddr, bus.WData}, {1'b1, 5'd8, 32'hABCD});
    chk("m_drained", {bus.count, bus.q_busy0}, {3'd0, 1'b0});

    // Contention: pipeline every cycle while the FIFO fills
    bus.p_valid = 1'b1; bus.p_addr = 5'd9;
    for (int i = 0; i < 4; i++) begin
      bus.p_data = 32'h90 + i; bus.p_pc = 32'h5000 + i;
      bus.m_valid = 1'b1; bus.m_addr = 5'(i + 1); bus.m_data = 32'h100 + i; bus.m_pc = 32'h6000 + i;
      exp_wr(5'd9, 32'h90 + i, 32'h5000 + i);
      step();
    end
    chk("full_count", bus.count, 4);
    chk("full_mready", bus.m_ready, 0);
    bus.p_data = 32'h94; bus.p_pc = 32'h5004; bus.m_addr = 5'd5;
    exp_wr(5'd9, 32'h94, 32'h5004);
    step();
    chk("full_hold", {bus.count, bus.m_ready, bus.Waddr}, {3'd4, 1'b0, 5'd9});
    bus.p_valid = 1'b0; bus.m_valid = 1'b0;
    for (int i = 0; i < 4; i++) exp_wr(5'(i + 1), 32'h100 + i, 32'h6000 + i);
    step();
    chk("drain0", {bus.RegWrite, bus.Waddr, bus.m_ready, bus.count}, {1'b1, 5'd1, 1'b1, 3'd3});
    for (int i = 1; i < 4; i++) begin
      step();
      chk("drain", {bus.RegWrite, bus.Waddr, bus.WData}, {1'b1, 5'(i + 1), 32'h100 + i});
    end
    step();
    chk("drain_idle", {bus.RegWrite, bus.count}, {1'b0, 3'd0});

    // Kill: older queued write superseded by a pipeline write
    bus.m_valid = 1'b1; bus.m_addr = 5'd7; bus.m_data = 32'h1; bus.m_pc = 32'h7000;
    step();
    bus.m_valid = 1'b0;
    bus.p_valid = 1'b1; bus.p_addr = 5'd7; bus.p_data = 32'h2; bus.p_pc = 32'h7004;
    exp_wr(5'd7, 32'h2, 32'h7004);
    bus.q_addr0 = 5'd7;
    #1;
    chk("kill_busy_pre", bus.q_busy0, 1);
    step();
    bus.p_valid = 1'b0;
    #1;
    chk("kill_busy_post", {bus.q_busy0, bus.count}, {1'b0, 3'd1});
    step();
    chk("kill_pop", {bus.RegWrite, bus.count, bus.WData}, {1'b0, 3'd0, 32'h2});

    // Same-edge push and pipeline write: the pushed entry is younger
    bus.m_valid = 1'b1; bus.m_addr = 5'd7; bus.m_data = 32'hA; bus.m_pc = 32'h8000;
    bus.p_valid = 1'b1; bus.p_addr = 5'd7; bus.p_data = 32'hB; bus.p_pc = 32'h8004;
    exp_wr(5'd7, 32'hB, 32'h8004);
    exp_wr(5'd7, 32'hA, 32'h8000);
    step();
    bus.m_valid = 1'b0; bus.p_valid = 1'b0;
    #1;
    chk("same_first", {bus.WData, bus.q_busy0}, {32'hB, 1'b1});
    step();
    chk("same_second", {bus.RegWrite, bus.WData}, {1'b1, 32'hA});

    // Reset asserted with three entries queued
    bus.p_valid = 1'b1; bus.p_addr = 5'd10; bus.m_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.p_data = 32'hA0 + i; bus.p_pc = 32'h9000 + i;
      bus.m_addr = 5'(11 + i); bus.m_data = 32'hC0 + i;
      exp_wr(5'd10, 32'hA0 + i, 32'h9000 + i);
      step();
    end
    bus.p_valid = 1'b0; bus.m_valid = 1'b0;
    chk("mid_count", bus.count, 3);
    #5;
    reset = 1'b0;
    #1;
    chk("mid_rst", {bus.count, bus.RegWrite, bus.m_ready}, 0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_idle", {bus.RegWrite, bus.count}, 0);
    end

    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
